amci_rr_arbiter: RTL and testbench
==================================

// Module: amci_rr_arbiter
// PURPOSE
//  Shares one AMCI port of the AXI4 no-burst master between NUM_CLIENTS requesters.
//  Write and read channels are arbitrated independently, round-robin, one transaction in flight each.
//  Clients use a level request / one-cycle done handshake; the arbiter sequences the master's
//  one-cycle AMCI_WRITE/AMCI_READ pulses and returns the response to the granted client.
// PARAMETERS
//  NUM_CLIENTS     2   number of requesters, 2..8
//  AXI_DATA_WIDTH  32  AMCI data width (bits)
//  AXI_ADDR_WIDTH  32  AMCI address width (bits)
// PORTS  (N=NUM_CLIENTS, A=AXI_ADDR_WIDTH, D=AXI_DATA_WIDTH; client i occupies slice [i*W +: W])
//  clk        in   1    clock
//  resetn     in   1    synchronous, active-low reset
//  c_wreq     in   N    client write request, level, held until c_wdone
//  c_waddr    in   N*A  write address per client
//  c_wdata    in   N*D  write data per client, right-justified
//  c_wsize    in   N*3  log2 bytes per client
//  c_wdone    out  N    one-cycle pulse: write complete
//  c_wresp    out  2    BRESP of the last completed write, valid while c_wdone is high
//  c_rreq     in   N    client read request, level, held until c_rdone
//  c_raddr    in   N*A  read address per client
//  c_rsize    in   N*3  log2 bytes per client
//  c_rdone    out  N    one-cycle pulse: read complete
//  c_rdata    out  D    read data, right-justified, valid while c_rdone is high
//  c_rresp    out  2    RRESP, valid while c_rdone is high
//  m_waddr/m_wdata/m_wsize/m_write  out  A/D/3/1  to master AMCI write inputs
//  m_wresp, m_widle                 in   2/1      from master
//  m_raddr/m_rsize/m_read           out  A/3/1    to master AMCI read inputs
//  m_rdata, m_rresp, m_ridle        in   D/2/1    from master
// BEHAVIOUR
//  Reset: all FSMs IDLE; m_write=m_read=0; c_wdone=c_rdone=0; last_wgrant=last_rgrant=N-1
//   (client 0 wins first). m_* address/data/size and c_wresp/c_rdata/c_rresp reset to 0.
//  Write FSM: IDLE -> ISSUE -> WAIT -> DONE -> IDLE. Read FSM is identical, with r signals in place of w.
//   IDLE:  if |c_wreq && m_widle, grant g = first set bit at or after last_wgrant+1 (mod N).
//          Register m_waddr/m_wdata/m_wsize from slice g; m_write<=1; last_wgrant<=g.
//   ISSUE: m_write is high for exactly this one cycle; m_write<=0.
//   WAIT:  m_widle is low throughout this state (master busy). On m_widle==1, c_wresp<=m_wresp
//          and c_wdone[g]<=1.
//   DONE:  c_wdone one-hot high for 1 cycle, then cleared. No arbitration this cycle, so the
//          client drops c_wreq at this edge.
//  Latency: request sampled at edge T -> m_write high in cycle T+1 -> c_wdone high the cycle after
//   m_widle is seen. Minimum 5 cycles per transaction per channel.
//  m_* outputs change only in IDLE at grant. They are stable from ISSUE through DONE.
//  Request deasserted before done: the transaction still completes and done still pulses.
//  Simultaneous write and read from the same or different clients proceed concurrently.
//  c_wdone and c_rdone may pulse in the same cycle.
//  Request held after done: that client becomes the lowest priority. Another client's pending
//   request wins next.
//  m_widle low in IDLE (master externally busy): no grant until it rises.
//  Reset mid-operation: FSMs return to IDLE on the next edge and no done is issued. The master
//   shares resetn.
// STRUCTURE
//  amci_defs.vh: FSM state encodings (2-bit IDLE/ISSUE/WAIT/DONE), AMCI response codes OKAY/SLVERR/DECERR.
//  Sub-module rr_pick #(N): combinational, (req[N], last[clog2 N]) -> (any, grant index).
//  Instantiated twice, once for writes and once for reads.
//  Top level: two FSMs, slice muxes, response registers.
// TESTING  (N=2, 32-bit; bench model of the master with a programmable busy time)
//  1. c_wreq=01, addr 0x1000, data 0xDEADBEEF, size 2 -> single m_write pulse with those values;
//     c_wdone=01 for 1 cycle; c_wresp=0.
//  2. c_wreq=11 held continuously -> grants alternate 0,1,0,1. Neither client waits for more than
//     one other transaction.
//  3. Write from client 0 and read from client 1 at the same edge -> m_write and m_read both pulse
//     in the same cycle; both dones arrive; c_rdata equals the model data 0x0000A5A5.
//  4. Model returns RRESP=2 with a 10-cycle busy time -> c_rresp=2 on c_rdone.
//     m_raddr stays stable for the whole busy window.
//  5. m_widle forced low in IDLE with c_wreq=01 -> no m_write until m_widle rises, then exactly
//     one pulse.
//  6. resetn low for 1 cycle during WAIT -> no done pulse; all outputs at reset values;
//     the next request is served normally by client 0.

Source files
------------

// File: rtl/amci_rr_arbiter_pkg.sv
// Shared types for the AMCI round-robin arbiter: channel FSM states, AMCI response codes,
// and the grant-index width helper.
package amci_rr_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } chan_state_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } amci_resp_e;

    // Grant index width; never zero so a 1-client build still has a legal vector.
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/amci_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after last+1, wrapping modulo N.
module amci_rr_arbiter_rr_pick
    import amci_rr_arbiter_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = idx_bits(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic          any,
    output logic [IW-1:0] grant
);

    assign any = |req;

    // NOTE: every always_comb output gets a default before any branch, otherwise a path
    // that skips the assignment infers a latch.
    always_comb begin
        logic found;
        found = 1'b0;
        grant = '0;
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (int'(last) + k) % N;
            if (!found && req[IW'(idx)]) begin
                grant = IW'(idx);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/amci_rr_arbiter.sv
// Shares one AMCI port between NUM_CLIENTS requesters; write and read channels are arbitrated
// independently, round-robin, with one transaction in flight per channel.
module amci_rr_arbiter
    import amci_rr_arbiter_pkg::*;
#(
    parameter int NUM_CLIENTS    = 2,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 32
) (
    input  logic                                  clk,
    input  logic                                  resetn,
    input  logic [NUM_CLIENTS-1:0]                c_wreq,
    input  logic [NUM_CLIENTS*AXI_ADDR_WIDTH-1:0] c_waddr,
    input  logic [NUM_CLIENTS*AXI_DATA_WIDTH-1:0] c_wdata,
    input  logic [NUM_CLIENTS*3-1:0]              c_wsize,
    output logic [NUM_CLIENTS-1:0]                c_wdone,
    output logic [1:0]                            c_wresp,
    input  logic [NUM_CLIENTS-1:0]                c_rreq,
    input  logic [NUM_CLIENTS*AXI_ADDR_WIDTH-1:0] c_raddr,
    input  logic [NUM_CLIENTS*3-1:0]              c_rsize,
    output logic [NUM_CLIENTS-1:0]                c_rdone,
    output logic [AXI_DATA_WIDTH-1:0]             c_rdata,
    output logic [1:0]                            c_rresp,
    output logic [AXI_ADDR_WIDTH-1:0]             m_waddr,
    output logic [AXI_DATA_WIDTH-1:0]             m_wdata,
    output logic [2:0]                            m_wsize,
    output logic                                  m_write,
    input  logic [1:0]                            m_wresp,
    input  logic                                  m_widle,
    output logic [AXI_ADDR_WIDTH-1:0]             m_raddr,
    output logic [2:0]                            m_rsize,
    output logic                                  m_read,
    input  logic [AXI_DATA_WIDTH-1:0]             m_rdata,
    input  logic [1:0]                            m_rresp,
    input  logic                                  m_ridle
);

    localparam int N  = NUM_CLIENTS;
    localparam int A  = AXI_ADDR_WIDTH;
    localparam int D  = AXI_DATA_WIDTH;
    localparam int IW = idx_bits(N);

    chan_state_e   w_state_q, w_state_d, r_state_q, r_state_d;
    logic [IW-1:0] last_wgrant_q, last_wgrant_d, last_rgrant_q, last_rgrant_d;
    logic [A-1:0]  m_waddr_q, m_waddr_d, m_raddr_q, m_raddr_d;
    logic [D-1:0]  m_wdata_q, m_wdata_d, c_rdata_q, c_rdata_d;
    logic [2:0]    m_wsize_q, m_wsize_d, m_rsize_q, m_rsize_d;
    logic          m_write_q, m_write_d, m_read_q, m_read_d;
    logic [N-1:0]  c_wdone_q, c_wdone_d, c_rdone_q, c_rdone_d;
    logic [1:0]    c_wresp_q, c_wresp_d, c_rresp_q, c_rresp_d;

    logic          w_any, r_any;
    logic [IW-1:0] w_pick, r_pick;

    amci_rr_arbiter_rr_pick #(.N(N), .IW(IW)) u_wpick (
        .req   (c_wreq),
        .last  (last_wgrant_q),
        .any   (w_any),
        .grant (w_pick)
    );

    amci_rr_arbiter_rr_pick #(.N(N), .IW(IW)) u_rpick (
        .req   (c_rreq),
        .last  (last_rgrant_q),
        .any   (r_any),
        .grant (r_pick)
    );

    // Write channel: the granted index stays in last_wgrant_q and steers the done pulse.
    always_comb begin
        w_state_d     = w_state_q;
        last_wgrant_d = last_wgrant_q;
        m_waddr_d     = m_waddr_q;
        m_wdata_d     = m_wdata_q;
        m_wsize_d     = m_wsize_q;
        m_write_d     = 1'b0;
        c_wdone_d     = '0;
        c_wresp_d     = c_wresp_q;
        case (w_state_q)
            ST_IDLE: begin
                if (w_any && m_widle) begin
                    w_state_d     = ST_ISSUE;
                    last_wgrant_d = w_pick;
                    m_waddr_d     = c_waddr[int'(w_pick)*A +: A];
                    m_wdata_d     = c_wdata[int'(w_pick)*D +: D];
                    m_wsize_d     = c_wsize[int'(w_pick)*3 +: 3];
                    m_write_d     = 1'b1;
                end
            end
            ST_ISSUE: w_state_d = ST_WAIT;
            ST_WAIT: begin
                if (m_widle) begin
                    w_state_d = ST_DONE;
                    c_wresp_d = m_wresp;
                    c_wdone_d = N'(1) << last_wgrant_q;
                end
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        r_state_d     = r_state_q;
        last_rgrant_d = last_rgrant_q;
        m_raddr_d     = m_raddr_q;
        m_rsize_d     = m_rsize_q;
        m_read_d      = 1'b0;
        c_rdone_d     = '0;
        c_rdata_d     = c_rdata_q;
        c_rresp_d     = c_rresp_q;
        case (r_state_q)
            ST_IDLE: begin
                if (r_any && m_ridle) begin
                    r_state_d     = ST_ISSUE;
                    last_rgrant_d = r_pick;
                    m_raddr_d     = c_raddr[int'(r_pick)*A +: A];
                    m_rsize_d     = c_rsize[int'(r_pick)*3 +: 3];
                    m_read_d      = 1'b1;
                end
            end
            ST_ISSUE: r_state_d = ST_WAIT;
            ST_WAIT: begin
                if (m_ridle) begin
                    r_state_d = ST_DONE;
                    c_rdata_d = m_rdata;
                    c_rresp_d = m_rresp;
                    c_rdone_d = N'(1) << last_rgrant_q;
                end
            end
            default: r_state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            w_state_q     <= ST_IDLE;
            r_state_q     <= ST_IDLE;
            last_wgrant_q <= IW'(N - 1);
            last_rgrant_q <= IW'(N - 1);
            m_waddr_q     <= '0;
            m_wdata_q     <= '0;
            m_wsize_q     <= '0;
            m_write_q     <= 1'b0;
            m_raddr_q     <= '0;
            m_rsize_q     <= '0;
            m_read_q      <= 1'b0;
            c_wdone_q     <= '0;
            c_wresp_q     <= RESP_OKAY;
            c_rdone_q     <= '0;
            c_rdata_q     <= '0;
            c_rresp_q     <= RESP_OKAY;
        end else begin
            w_state_q     <= w_state_d;
            r_state_q     <= r_state_d;
            last_wgrant_q <= last_wgrant_d;
            last_rgrant_q <= last_rgrant_d;
            m_waddr_q     <= m_waddr_d;
            m_wdata_q     <= m_wdata_d;
            m_wsize_q     <= m_wsize_d;
            m_write_q     <= m_write_d;
            m_raddr_q     <= m_raddr_d;
            m_rsize_q     <= m_rsize_d;
            m_read_q      <= m_read_d;
            c_wdone_q     <= c_wdone_d;
            c_wresp_q     <= c_wresp_d;
            c_rdone_q     <= c_rdone_d;
            c_rdata_q     <= c_rdata_d;
            c_rresp_q     <= c_rresp_d;
        end
    end

    assign m_waddr = m_waddr_q;
    assign m_wdata = m_wdata_q;
    assign m_wsize = m_wsize_q;
    assign m_write = m_write_q;
    assign m_raddr = m_raddr_q;
    assign m_rsize = m_rsize_q;
    assign m_read  = m_read_q;
    assign c_wdone = c_wdone_q;
    assign c_wresp = c_wresp_q;
    assign c_rdone = c_rdone_q;
    assign c_rdata = c_rdata_q;
    assign c_rresp = c_rresp_q;

endmodule

// File: tb/tb_amci_rr_arbiter.sv
// Scoreboard bench for amci_rr_arbiter (N=2, 32-bit) against a master model with a
// programmable busy time.
module tb_amci_rr_arbiter;
    import amci_rr_arbiter_pkg::*;

    localparam int N = 2;
    localparam int A = 32;
    localparam int D = 32;

    logic           clk = 1'b0;
    logic           resetn;
    logic [N-1:0]   c_wreq, c_rreq, c_wdone, c_rdone;
    logic [N*A-1:0] c_waddr, c_raddr;
    logic [N*D-1:0] c_wdata;
    logic [N*3-1:0] c_wsize, c_rsize;
    logic [1:0]     c_wresp, c_rresp;
    logic [D-1:0]   c_rdata;
    logic [A-1:0]   m_waddr, m_raddr;
    logic [D-1:0]   m_wdata, m_rdata;
    logic [2:0]     m_wsize, m_rsize;
    logic           m_write, m_read, m_widle, m_ridle;
    logic [1:0]     m_wresp, m_rresp;

    always #5 clk = ~clk;

    amci_rr_arbiter #(.NUM_CLIENTS(N), .AXI_DATA_WIDTH(D), .AXI_ADDR_WIDTH(A)) dut (
        .clk(clk), .resetn(resetn),
        .c_wreq(c_wreq), .c_waddr(c_waddr), .c_wdata(c_wdata), .c_wsize(c_wsize),
        .c_wdone(c_wdone), .c_wresp(c_wresp),
        .c_rreq(c_rreq), .c_raddr(c_raddr), .c_rsize(c_rsize),
        .c_rdone(c_rdone), .c_rdata(c_rdata), .c_rresp(c_rresp),
        .m_waddr(m_waddr), .m_wdata(m_wdata), .m_wsize(m_wsize), .m_write(m_write),
        .m_wresp(m_wresp), .m_widle(m_widle),
        .m_raddr(m_raddr), .m_rsize(m_rsize), .m_read(m_read),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_ridle(m_ridle)
    );

    // Master model: goes busy on the edge that samples a request pulse, for busy_time cycles.
    int unsigned  w_busy_time = 2, r_busy_time = 2, w_cnt, r_cnt;
    logic         w_model_idle, r_model_idle;
    logic         w_ext_busy = 1'b0;
    logic [1:0]   w_resp_model = 2'b00, r_resp_model = 2'b00;
    logic [D-1:0] r_data_model = '0;

    assign m_widle = w_model_idle & ~w_ext_busy;
    assign m_ridle = r_model_idle;

    always @(posedge clk) begin
        if (!resetn) begin
            w_model_idle <= 1'b1;
            w_cnt        <= 0;
            m_wresp      <= 2'b00;
        end else if (m_write) begin
            w_model_idle <= 1'b0;
            w_cnt        <= w_busy_time;
        end else if (!w_model_idle) begin
            if (w_cnt <= 1) begin
                w_model_idle <= 1'b1;
                m_wresp      <= w_resp_model;
            end else begin
                w_cnt <= w_cnt - 1;
            end
        end
    end

    always @(posedge clk) begin
        if (!resetn) begin
            r_model_idle <= 1'b1;
            r_cnt        <= 0;
            m_rdata      <= '0;
            m_rresp      <= 2'b00;
        end else if (m_read) begin
            r_model_idle <= 1'b0;
            r_cnt        <= r_busy_time;
        end else if (!r_model_idle) begin
            if (r_cnt <= 1) begin
                r_model_idle <= 1'b1;
                m_rdata      <= r_data_model;
                m_rresp      <= r_resp_model;
            end else begin
                r_cnt <= r_cnt - 1;
            end
        end
    end

    typedef struct packed {
        logic [A-1:0] addr;
        logic [D-1:0] data;
        logic [2:0]   size;
    } issue_t;

    typedef struct packed {
        logic [N-1:0] mask;
        logic [D-1:0] data;
        logic [1:0]   resp;
    } done_t;

    issue_t exp_wi[$], exp_ri[$];
    done_t  exp_wd[$], exp_rd[$];

    int n_cmp = 0, n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic issue_t mk_issue(input logic [A-1:0] a, input logic [D-1:0] d,
                                        input logic [2:0] s);
        issue_t t;
        t.addr = a; t.data = d; t.size = s;
        return t;
    endfunction

    function automatic done_t mk_done(input logic [N-1:0] m, input logic [D-1:0] d,
                                      input logic [1:0] r);
        done_t t;
        t.mask = m; t.data = d; t.resp = r;
        return t;
    endfunction

    task automatic set_w(input int c, input logic [A-1:0] a, input logic [D-1:0] d,
                         input logic [2:0] s);
        c_waddr[c*A +: A] = a;
        c_wdata[c*D +: D] = d;
        c_wsize[c*3 +: 3] = s;
    endtask

    task automatic set_r(input int c, input logic [A-1:0] a, input logic [2:0] s);
        c_raddr[c*A +: A] = a;
        c_rsize[c*3 +: 3] = s;
    endtask

    int           cyc = 0, w_issue_cyc = 0, r_issue_cyc = 0;
    int           w_issue_cnt = 0, w_done_cnt = 0;
    logic [N-1:0] hold_w = '0;
    logic         chk_raddr = 1'b0;
    logic [A-1:0] raddr_ref = '0;

    // One clock: sample on the falling edge, score DUT activity, let clients drop on done.
    task automatic step();
        issue_t ei;
        done_t  ed;
        @(negedge clk);
        cyc++;
        if (m_write) begin
            w_issue_cnt++;
            w_issue_cyc = cyc;
            check("w_issue_expected", 64'(exp_wi.size() > 0), 64'(1));
            if (exp_wi.size() > 0) begin
                ei = exp_wi.pop_front();
                check("m_waddr", 64'(m_waddr), 64'(ei.addr));
                check("m_wdata", 64'(m_wdata), 64'(ei.data));
                check("m_wsize", 64'(m_wsize), 64'(ei.size));
            end
        end
        if (m_read) begin
            r_issue_cyc = cyc;
            check("r_issue_expected", 64'(exp_ri.size() > 0), 64'(1));
            if (exp_ri.size() > 0) begin
                ei = exp_ri.pop_front();
                check("m_raddr", 64'(m_raddr), 64'(ei.addr));
                check("m_rsize", 64'(m_rsize), 64'(ei.size));
            end
        end
        if (c_wdone != '0) begin
            w_done_cnt++;
            check("w_done_expected", 64'(exp_wd.size() > 0), 64'(1));
            if (exp_wd.size() > 0) begin
                ed = exp_wd.pop_front();
                check("c_wdone", 64'(c_wdone), 64'(ed.mask));
                check("c_wresp", 64'(c_wresp), 64'(ed.resp));
            end
            c_wreq = c_wreq & ~(c_wdone & ~hold_w);
        end
        if (c_rdone != '0) begin
            check("r_done_expected", 64'(exp_rd.size() > 0), 64'(1));
            if (exp_rd.size() > 0) begin
                ed = exp_rd.pop_front();
                check("c_rdone", 64'(c_rdone), 64'(ed.mask));
                check("c_rdata", 64'(c_rdata), 64'(ed.data));
                check("c_rresp", 64'(c_rresp), 64'(ed.resp));
            end
            c_rreq = c_rreq & ~c_rdone;
        end
        if (chk_raddr && !m_ridle)
            check("m_raddr_stable", 64'(m_raddr), 64'(raddr_ref));
    endtask

    function automatic int pending();
        return exp_wi.size() + exp_ri.size() + exp_wd.size() + exp_rd.size();
    endfunction

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while (pending() != 0 && n < budget) begin
            step();
            n++;
        end
        check(tag, 64'(pending()), 64'(0));
        exp_wi.delete(); exp_ri.delete(); exp_wd.delete(); exp_rd.delete();
        repeat (2) step();
    endtask

    initial begin
        int base, n;
        c_wreq = '0; c_rreq = '0;
        c_waddr = '0; c_wdata = '0; c_wsize = '0; c_raddr = '0; c_rsize = '0;
        resetn = 1'b0;
        repeat (3) step();
        check("rst_m_write", 64'(m_write), 64'(0));
        check("rst_m_read",  64'(m_read),  64'(0));
        check("rst_c_wdone", 64'(c_wdone), 64'(0));
        check("rst_c_rdone", 64'(c_rdone), 64'(0));
        check("rst_m_waddr", 64'(m_waddr), 64'(0));
        check("rst_c_rdata", 64'(c_rdata), 64'(0));
        resetn = 1'b1;
        repeat (2) step();

        // Single write from client 0.
        set_w(0, 32'h1000, 32'hDEADBEEF, 3'd2);
        exp_wi.push_back(mk_issue(32'h1000, 32'hDEADBEEF, 3'd2));
        exp_wd.push_back(mk_done(2'b01, '0, RESP_OKAY));
        c_wreq = 2'b01;
        drain("t1_drain", 40);

        // Concurrent write (client 0) and read (client 1) requested at the same edge.
        set_w(0, 32'h4000, 32'hCAFEF00D, 3'd2);
        set_r(1, 32'h5000, 3'd2);
        r_data_model = 32'h0000A5A5;
        exp_wi.push_back(mk_issue(32'h4000, 32'hCAFEF00D, 3'd2));
        exp_wd.push_back(mk_done(2'b01, '0, RESP_OKAY));
        exp_ri.push_back(mk_issue(32'h5000, '0, 3'd2));
        exp_rd.push_back(mk_done(2'b10, 32'h0000A5A5, RESP_OKAY));
        w_issue_cyc = -1; r_issue_cyc = -2;
        c_wreq = 2'b01; c_rreq = 2'b10;
        drain("t3_drain", 40);
        check("t3_same_cycle", 64'(w_issue_cyc), 64'(r_issue_cyc));

        // Slow read with SLVERR; address must hold through the whole busy window.
        set_r(0, 32'h6000, 3'd1);
        r_busy_time = 10; r_resp_model = RESP_SLVERR; r_data_model = 32'h12345678;
        raddr_ref = 32'h6000; chk_raddr = 1'b1;
        exp_ri.push_back(mk_issue(32'h6000, '0, 3'd1));
        exp_rd.push_back(mk_done(2'b01, 32'h12345678, RESP_SLVERR));
        c_rreq = 2'b01;
        drain("t4_drain", 60);
        chk_raddr = 1'b0; r_busy_time = 2; r_resp_model = RESP_OKAY;

        // Master externally busy in IDLE: no issue until it frees up, then exactly one.
        set_w(0, 32'h7000, 32'h0BADC0DE, 3'd0);
        w_resp_model = RESP_DECERR;
        w_ext_busy = 1'b1;
        base = w_issue_cnt;
        c_wreq = 2'b01;
        repeat (6) step();
        check("t5_no_issue_busy", 64'(w_issue_cnt - base), 64'(0));
        exp_wi.push_back(mk_issue(32'h7000, 32'h0BADC0DE, 3'd0));
        exp_wd.push_back(mk_done(2'b01, '0, RESP_DECERR));
        w_ext_busy = 1'b0;
        drain("t5_drain", 40);
        check("t5_one_issue", 64'(w_issue_cnt - base), 64'(1));
        w_resp_model = RESP_OKAY;

        // Reset while the write channel is in WAIT: no done, everything back to reset values.
        set_w(1, 32'h8000, 32'h80808080, 3'd2);
        w_busy_time = 10;
        exp_wi.push_back(mk_issue(32'h8000, 32'h80808080, 3'd2));
        c_wreq = 2'b10;
        n = 0;
        while (exp_wi.size() != 0 && n < 20) begin
            step();
            n++;
        end
        check("t6_issued", 64'(exp_wi.size()), 64'(0));
        exp_wi.delete();
        repeat (2) step();
        base = w_done_cnt;
        resetn = 1'b0;
        c_wreq = '0;
        step();
        check("t6_rst_m_write", 64'(m_write), 64'(0));
        check("t6_rst_c_wdone", 64'(c_wdone), 64'(0));
        check("t6_rst_m_waddr", 64'(m_waddr), 64'(0));
        check("t6_rst_m_wdata", 64'(m_wdata), 64'(0));
        check("t6_rst_m_wsize", 64'(m_wsize), 64'(0));
        check("t6_rst_c_wresp", 64'(c_wresp), 64'(0));
        check("t6_rst_m_raddr", 64'(m_raddr), 64'(0));
        check("t6_rst_c_rdata", 64'(c_rdata), 64'(0));
        check("t6_rst_c_rresp", 64'(c_rresp), 64'(0));
        resetn = 1'b1;
        w_busy_time = 2;
        repeat (15) step();
        check("t6_no_done", 64'(w_done_cnt - base), 64'(0));

        // Both clients hold requests: client 0 wins first after reset, then strict alternation.
        set_w(0, 32'h9000, 32'h90909090, 3'd2);
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) begin
                exp_wi.push_back(mk_issue(32'h9000, 32'h90909090, 3'd2));
                exp_wd.push_back(mk_done(2'b01, '0, RESP_OKAY));
            end else begin
                exp_wi.push_back(mk_issue(32'h8000, 32'h80808080, 3'd2));
                exp_wd.push_back(mk_done(2'b10, '0, RESP_OKAY));
            end
        end
        hold_w = 2'b11;
        base = w_done_cnt;
        c_wreq = 2'b11;
        n = 0;
        while (w_done_cnt - base < 4 && n < 80) begin
            step();
            n++;
        end
        check("t2_four_dones", 64'(w_done_cnt - base), 64'(4));
        c_wreq = '0;
        hold_w = '0;
        drain("t2_drain", 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
